// File: rtl/fifo_flex_if.sv
// Request/response bundle for fifo_flex: write, read, flush and flag-clear
// requests in, data, occupancy and status flags out.
interface fifo_flex_if #(
  parameter int FIFO_WIDTH = 8,
  parameter int FIFO_DEPTH = 64
);
  localparam int CNT_WIDTH = $clog2(FIFO_DEPTH + 1);

  logic                  i_flush;
  logic                  i_write;
  logic [FIFO_WIDTH-1:0] i_wdata;
  logic                  i_read;
  logic                  i_clr_flags;
  logic [FIFO_WIDTH-1:0] o_rdata;
  logic                  o_empty;
  logic                  o_full;
  logic                  o_almost_empty;
  logic                  o_almost_full;
  logic [CNT_WIDTH-1:0]  o_count;
  logic                  o_overflow;
  logic                  o_underflow;

  modport master (
    output i_flush, i_write, i_wdata, i_read, i_clr_flags,
    input  o_rdata, o_empty, o_full, o_almost_empty, o_almost_full,
           o_count, o_overflow, o_underflow
  );

  modport slave (
    input  i_flush, i_write, i_wdata, i_read, i_clr_flags,
    output o_rdata, o_empty, o_full, o_almost_empty, o_almost_full,
           o_count, o_overflow, o_underflow
  );
endinterface

// File: rtl/fifo_flex.sv
// Single-clock FIFO of arbitrary depth with registered or show-ahead output,
// programmable almost flags, sticky error flags and synchronous flush.
module fifo_flex #(
  parameter int FIFO_DEPTH    = 64,
  parameter int FIFO_WIDTH    = 8,
  parameter bit FWFT          = 1'b0,
  parameter int AFULL_THRESH  = FIFO_DEPTH - 1,
  parameter int AEMPTY_THRESH = 1
) (
  input  logic       i_clk,
  input  logic       i_rst_n,
  fifo_flex_if.slave bus
);
  localparam int PTR_WIDTH = $clog2(FIFO_DEPTH);
  localparam int CNT_WIDTH = $clog2(FIFO_DEPTH + 1);
  localparam logic [PTR_WIDTH-1:0] PTR_LAST = PTR_WIDTH'(FIFO_DEPTH - 1);
  localparam logic [CNT_WIDTH-1:0] CNT_FULL = CNT_WIDTH'(FIFO_DEPTH);

  logic [FIFO_WIDTH-1:0] mem_q [FIFO_DEPTH];
  logic [PTR_WIDTH-1:0]  ptr_w_q, ptr_w_d;
  logic [PTR_WIDTH-1:0]  ptr_r_q, ptr_r_d;
  logic [CNT_WIDTH-1:0]  count_q, count_d;
  logic                  overflow_q, overflow_d;
  logic                  underflow_q, underflow_d;
  logic                  empty, full, rd_ok, wr_ok;

  assign empty = (count_q == '0);
  assign full  = (count_q == CNT_FULL);

  always_comb begin
    // NOTE: every output of this block gets a default first, so no path can
    // leave a signal unassigned and infer a latch.
    ptr_w_d     = ptr_w_q;
    ptr_r_d     = ptr_r_q;
    count_d     = count_q;
    rd_ok       = bus.i_read & ~empty & ~bus.i_flush;
    wr_ok       = bus.i_write & (~full | rd_ok) & ~bus.i_flush;
    overflow_d  = (overflow_q & ~bus.i_clr_flags) | (bus.i_write & ~wr_ok & ~bus.i_flush);
    underflow_d = (underflow_q & ~bus.i_clr_flags) | (bus.i_read & ~rd_ok & ~bus.i_flush);

    if (bus.i_flush) begin
      ptr_w_d = '0;
      ptr_r_d = '0;
      count_d = '0;
    end else begin
      // Explicit wrap so depths that are not powers of two work.
      if (wr_ok) ptr_w_d = (ptr_w_q == PTR_LAST) ? '0 : ptr_w_q + PTR_WIDTH'(1);
      if (rd_ok) ptr_r_d = (ptr_r_q == PTR_LAST) ? '0 : ptr_r_q + PTR_WIDTH'(1);
      case ({wr_ok, rd_ok})
        2'b10:   count_d = count_q + CNT_WIDTH'(1);
        2'b01:   count_d = count_q - CNT_WIDTH'(1);
        default: count_d = count_q;
      endcase
    end
  end

  // NOTE: state uses non-blocking assignments so every flop samples the
  // pre-edge values; the reset here is synchronous and sampled on the edge.
  always_ff @(posedge i_clk) begin
    if (!i_rst_n) begin
      ptr_w_q     <= '0;
      ptr_r_q     <= '0;
      count_q     <= '0;
      overflow_q  <= 1'b0;
      underflow_q <= 1'b0;
    end else begin
      ptr_w_q     <= ptr_w_d;
      ptr_r_q     <= ptr_r_d;
      count_q     <= count_d;
      overflow_q  <= overflow_d;
      underflow_q <= underflow_d;
    end
  end

  // NOTE: storage has no reset; the pointers and count define what is valid,
  // and leaving the array unreset lets it map onto plain RAM.
  always_ff @(posedge i_clk) begin
    if (wr_ok) mem_q[ptr_w_q] <= bus.i_wdata;
  end

  if (FWFT) begin : g_show_ahead
    assign bus.o_rdata = mem_q[ptr_r_q];
  end else begin : g_registered
    logic [FIFO_WIDTH-1:0] rdata_q, rdata_d;

    always_comb rdata_d = rd_ok ? mem_q[ptr_r_q] : rdata_q;

    always_ff @(posedge i_clk) begin
      if (!i_rst_n) rdata_q <= '0;
      else          rdata_q <= rdata_d;
    end

    assign bus.o_rdata = rdata_q;
  end

  assign bus.o_empty        = empty;
  assign bus.o_full         = full;
  assign bus.o_almost_empty = (int'(count_q) <= AEMPTY_THRESH);
  assign bus.o_almost_full  = (int'(count_q) >= AFULL_THRESH);
  assign bus.o_count        = count_q;
  assign bus.o_overflow     = overflow_q;
  assign bus.o_underflow    = underflow_q;
endmodule

// File: tb/tb_fifo_flex.sv
// Bench for fifo_flex: three configurations driven by directed and random
// stimulus, all outputs compared each cycle against a queue-based model.
module tb_fifo_flex;
  logic clk = 1'b0;
  logic rst_n = 1'b1;
  always #5 clk = ~clk;

  fifo_flex_if #(.FIFO_WIDTH(8), .FIFO_DEPTH(5)) bus0 ();
  fifo_flex_if #(.FIFO_WIDTH(8), .FIFO_DEPTH(4)) bus1 ();
  fifo_flex_if #(.FIFO_WIDTH(8), .FIFO_DEPTH(8)) bus2 ();

  fifo_flex #(.FIFO_DEPTH(5), .FIFO_WIDTH(8), .FWFT(1'b0), .AFULL_THRESH(4), .AEMPTY_THRESH(1))
    u_dut0 (.i_clk(clk), .i_rst_n(rst_n), .bus(bus0.slave));
  fifo_flex #(.FIFO_DEPTH(4), .FIFO_WIDTH(8), .FWFT(1'b1), .AFULL_THRESH(3), .AEMPTY_THRESH(1))
    u_dut1 (.i_clk(clk), .i_rst_n(rst_n), .bus(bus1.slave));
  fifo_flex #(.FIFO_DEPTH(8), .FIFO_WIDTH(8), .FWFT(1'b0), .AFULL_THRESH(6), .AEMPTY_THRESH(2))
    u_dut2 (.i_clk(clk), .i_rst_n(rst_n), .bus(bus2.slave));

  int depth_a  [3] = '{5, 4, 8};
  int fwft_a   [3] = '{0, 1, 0};
  int afull_a  [3] = '{4, 3, 6};
  int aempty_a [3] = '{1, 1, 2};

  typedef struct {
    logic [31:0] rdata, count, empty, full, aempty, afull, ovf, unf;
  } obs_t;

  int sel = 0;
  int n_checks = 0;
  int n_fail = 0;

  // Reference model: contents as a queue, flags and registered read data.
  logic [7:0] mq [$];
  logic       m_ovf, m_unf;
  logic [7:0] m_rdata;

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_checks++;
    if (obs !== exp) begin
      n_fail++;
      $display("FAIL %s (dut %0d, t=%0t): got 0x%0h expected 0x%0h", tag, sel, $time, obs, exp);
    end
  endtask

  function automatic obs_t sample();
    obs_t o;
    case (sel)
      0: o = '{32'(bus0.o_rdata), 32'(bus0.o_count), 32'(bus0.o_empty), 32'(bus0.o_full),
               32'(bus0.o_almost_empty), 32'(bus0.o_almost_full), 32'(bus0.o_overflow), 32'(bus0.o_underflow)};
      1: o = '{32'(bus1.o_rdata), 32'(bus1.o_count), 32'(bus1.o_empty), 32'(bus1.o_full),
               32'(bus1.o_almost_empty), 32'(bus1.o_almost_full), 32'(bus1.o_overflow), 32'(bus1.o_underflow)};
      default: o = '{32'(bus2.o_rdata), 32'(bus2.o_count), 32'(bus2.o_empty), 32'(bus2.o_full),
               32'(bus2.o_almost_empty), 32'(bus2.o_almost_full), 32'(bus2.o_overflow), 32'(bus2.o_underflow)};
    endcase
    return o;
  endfunction

  task automatic drive(input logic fl, input logic wr, input logic [7:0] wd, input logic rd, input logic clr);
    bus0.i_flush = (sel == 0) & fl; bus0.i_write = (sel == 0) & wr; bus0.i_wdata = wd;
    bus0.i_read  = (sel == 0) & rd; bus0.i_clr_flags = (sel == 0) & clr;
    bus1.i_flush = (sel == 1) & fl; bus1.i_write = (sel == 1) & wr; bus1.i_wdata = wd;
    bus1.i_read  = (sel == 1) & rd; bus1.i_clr_flags = (sel == 1) & clr;
    bus2.i_flush = (sel == 2) & fl; bus2.i_write = (sel == 2) & wr; bus2.i_wdata = wd;
    bus2.i_read  = (sel == 2) & rd; bus2.i_clr_flags = (sel == 2) & clr;
  endtask

  task automatic model_step(input logic fl, input logic wr, input logic [7:0] wd, input logic rd, input logic clr);
    bit rok, wok;
    m_ovf = m_ovf & ~clr;
    m_unf = m_unf & ~clr;
    if (fl) begin
      mq.delete();
    end else begin
      rok = rd && (mq.size() > 0);
      wok = wr && ((mq.size() < depth_a[sel]) || rok);
      if (wr && !wok) m_ovf = 1'b1;
      if (rd && !rok) m_unf = 1'b1;
      if (rok) begin
        if (fwft_a[sel] == 0) m_rdata = mq[0];
        void'(mq.pop_front());
      end
      if (wok) mq.push_back(wd);
    end
  endtask

  task automatic compare_all();
    obs_t o = sample();
    int n = mq.size();
    if (fwft_a[sel] == 0) check("rdata", o.rdata, 32'(m_rdata));
    else if (n > 0)       check("rdata_head", o.rdata, 32'(mq[0]));
    check("count",  o.count,  32'(n));
    check("empty",  o.empty,  32'(n == 0));
    check("full",   o.full,   32'(n == depth_a[sel]));
    check("aempty", o.aempty, 32'(n <= aempty_a[sel]));
    check("afull",  o.afull,  32'(n >= afull_a[sel]));
    check("ovf",    o.ovf,    32'(m_ovf));
    check("unf",    o.unf,    32'(m_unf));
  endtask

  task automatic cyc(input logic fl, input logic wr, input logic [7:0] wd, input logic rd, input logic clr);
    drive(fl, wr, wd, rd, clr);
    @(posedge clk);
    model_step(fl, wr, wd, rd, clr);
    #1;
    compare_all();
    drive(1'b0, 1'b0, 8'h00, 1'b0, 1'b0);
  endtask

  // Reset is applied with read and write also requested: reset must win.
  task automatic do_reset();
    drive(1'b0, 1'b1, 8'hEE, 1'b1, 1'b0);
    rst_n = 1'b0;
    @(posedge clk);
    #1;
    rst_n = 1'b1;
    drive(1'b0, 1'b0, 8'h00, 1'b0, 1'b0);
    mq.delete();
    m_ovf = 1'b0; m_unf = 1'b0; m_rdata = 8'h00;
    compare_all();
  endtask

  initial begin
    obs_t o;
    logic [7:0] exp_seq [5];
    drive(1'b0, 1'b0, 8'h00, 1'b0, 1'b0);
    #1;

    // DEPTH=5 registered read: fill, overflow, drain in order.
    sel = 0;
    do_reset();
    for (int i = 1; i <= 5; i++) cyc(1'b0, 1'b1, 8'(i), 1'b0, 1'b0);
    o = sample(); check("d0_full", o.full, 32'd1); check("d0_count5", o.count, 32'd5);
    cyc(1'b0, 1'b1, 8'd6, 1'b0, 1'b0);
    o = sample(); check("d0_ovf_set", o.ovf, 32'd1);
    for (int i = 1; i <= 5; i++) begin
      cyc(1'b0, 1'b0, 8'h00, 1'b1, 1'b0);
      o = sample(); check("d0_drain", o.rdata, 32'(i));
    end
    o = sample(); check("d0_empty", o.empty, 32'd1);

    // Pass-through write at full, then drain across the pointer wrap.
    cyc(1'b0, 1'b0, 8'h00, 1'b0, 1'b1);
    for (int i = 1; i <= 5; i++) cyc(1'b0, 1'b1, 8'(i), 1'b0, 1'b0);
    cyc(1'b0, 1'b1, 8'd9, 1'b1, 1'b0);
    o = sample(); check("d0_pt_count", o.count, 32'd5); check("d0_pt_ovf", o.ovf, 32'd0);
    exp_seq = '{8'd2, 8'd3, 8'd4, 8'd5, 8'd9};
    for (int i = 0; i < 5; i++) begin
      cyc(1'b0, 1'b0, 8'h00, 1'b1, 1'b0);
      o = sample(); check("d0_wrap_drain", o.rdata, 32'(exp_seq[i]));
    end

    // Read at empty with a simultaneous write; set-wins-over-clear.
    cyc(1'b0, 1'b1, 8'h11, 1'b1, 1'b0);
    o = sample(); check("d0_unf_set", o.unf, 32'd1); check("d0_unf_count", o.count, 32'd1);
    cyc(1'b1, 1'b0, 8'h00, 1'b0, 1'b0);
    cyc(1'b0, 1'b0, 8'h00, 1'b1, 1'b1);
    o = sample(); check("d0_set_wins", o.unf, 32'd1);
    cyc(1'b0, 1'b0, 8'h00, 1'b0, 1'b1);
    o = sample(); check("d0_clr", o.unf, 32'd0);

    // Flush beats read/write and raises no flags; then reset mid-stream.
    for (int i = 0; i < 3; i++) cyc(1'b0, 1'b1, 8'(8'h40 + i), 1'b0, 1'b0);
    cyc(1'b1, 1'b1, 8'h77, 1'b1, 1'b0);
    o = sample(); check("d0_flush_count", o.count, 32'd0); check("d0_flush_empty", o.empty, 32'd1);
    check("d0_flush_flags", o.ovf | o.unf, 32'd0);
    for (int i = 0; i < 6; i++) cyc(1'b0, 1'b1, 8'(8'h50 + i), 1'b0, 1'b0);
    cyc(1'b0, 1'b0, 8'h00, 1'b1, 1'b0);
    o = sample(); check("d0_pre_rst_count", o.count, 32'd4); check("d0_pre_rst_ovf", o.ovf, 32'd1);
    do_reset();
    o = sample(); check("d0_rst_count", o.count, 32'd0); check("d0_rst_ovf", o.ovf, 32'd0);
    check("d0_rst_rdata", o.rdata, 32'd0);

    // Show-ahead: word visible the cycle after it is written.
    sel = 1;
    do_reset();
    cyc(1'b0, 1'b1, 8'hA5, 1'b0, 1'b0);
    o = sample(); check("d1_fwft_empty", o.empty, 32'd0); check("d1_fwft_head", o.rdata, 32'hA5);
    cyc(1'b0, 1'b1, 8'h3C, 1'b1, 1'b0);
    o = sample(); check("d1_fwft_next", o.rdata, 32'h3C); check("d1_fwft_count", o.count, 32'd1);

    // Almost-flag thresholds across a full fill and drain.
    sel = 2;
    do_reset();
    for (int i = 0; i < 8; i++) cyc(1'b0, 1'b1, 8'(8'hC0 + i), 1'b0, 1'b0);
    for (int i = 0; i < 8; i++) cyc(1'b0, 1'b0, 8'h00, 1'b1, 1'b0);

    // Random traffic on each configuration with drifting read/write bias.
    for (int s = 0; s < 3; s++) begin
      int wr_pct, rd_pct;
      sel = s;
      do_reset();
      for (int c = 0; c < 400; c++) begin
        if (c % 50 == 0) begin
          wr_pct = int'($urandom_range(90, 10));
          rd_pct = int'($urandom_range(90, 10));
        end
        cyc(($urandom % 40) == 0, int'($urandom % 100) < wr_pct, 8'($urandom),
            int'($urandom % 100) < rd_pct, ($urandom % 25) == 0);
      end
    end

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end
endmodule
